miner_core_msa_stream: RTL
==========================

MINER_CORE_MSA_STREAM -- requirements
Module: miner_core_msa_stream

Interface
REQ-001 SHALL have parameter SHA512, default 0, meaning 0 = SHA-256 schedule (32-bit words, 64 rounds) and 1 = SHA-512 schedule (64-bit words, 80 rounds).
REQ-002 SHALL derive localparam WORD_W = 32/64 and ROUNDS = 64/80 from SHA512; neither is overridable.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load_valid  input  1  chunk present.
REQ-007 load_ready  output  1  block idle, chunk can be accepted.
REQ-008 chunk  input  16*WORD_W  message block; word 0 at the MSBs.
REQ-009 abort  input  1  synchronous cancel of the current schedule.
REQ-010 w_valid  output  1  w_data holds schedule word W[t].
REQ-011 w_ready  input  1  consumer accepts W[t].
REQ-012 w_data  output  WORD_W  schedule word W[t].
REQ-013 w_idx  output  7  round index t.
REQ-014 w_last  output  1  high with w_valid when t == ROUNDS-1.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and RUN.
REQ-016 IDLE: load_ready=1 and w_valid=0; load_valid&&load_ready SHALL capture chunk into a 16-word window win[0..15], set t=0, and go to RUN.
REQ-017 RUN: load_ready=0; load_valid SHALL be ignored.
REQ-018 RUN: w_valid=1, w_data=win[0], w_idx=t; first W[0] SHALL appear the cycle after load acceptance (latency 1).
REQ-019 Transfer = w_valid&&w_ready; on transfer the window SHALL shift (win[k]<=win[k+1]), win[15]<=new word, t<=t+1.
REQ-020 New word SHALL be sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], truncated mod 2^WORD_W (carries discarded).
REQ-021 SHA256 sigma functions: sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
REQ-022 SHA512 sigma functions: sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
REQ-023 w_valid=1 with w_ready=0 SHALL hold w_data, w_idx and w_last stable; no limit on stall length.
REQ-024 Transfer with t==ROUNDS-1 SHALL return the FSM to IDLE; load_ready SHALL be 1 the next cycle (one bubble between blocks).
REQ-025 abort=1 in any state SHALL force IDLE next cycle with w_valid=0; abort SHALL take priority over a simultaneous transfer or load.
REQ-026 w_data, w_idx and w_last SHALL come from registers; no combinational path from w_ready to w_valid or w_data.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, t=0, window=0, w_valid=0, w_last=0, w_data=0 and w_idx=0.
REQ-028 load_ready SHALL be 1 while rst=1 and after rst is released.
REQ-029 Reset mid-RUN SHALL discard the schedule; the first post-reset cycle is idle.

Structure
REQ-030 Package miner_core_pkg SHALL hold the SHA-256/512 round counts, word widths, rotate/shift constants and the FSM state typedef.
REQ-031 Sub-module miner_core_sigma (parameter SHA512; inputs x_lo, x_hi; outputs s0, s1) SHALL implement sigma0/sigma1 combinationally; this is the only sub-module.

Verification
REQ-032 SHA512=0, padded "abc" block (W0=0x61626380, W15=0x00000018, others 0), w_ready=1 -> W16=0x61626380, W17=0x000F0000, w_last at t=63 only, load_ready=1 next cycle.
REQ-033 SHA512=1, padded "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words, w_last at t=79.
REQ-034 Backpressure: w_ready toggled pseudo-randomly, including a 10-cycle stall at t=16 -> identical word sequence; outputs stable during stalls.
REQ-035 abort asserted at t=30 together with w_ready=1 -> w_valid=0 next cycle, load_ready=1; a new load restarts at t=0 with the correct W0.
REQ-036 rst pulsed mid-RUN (t=40) -> all outputs zero, load_ready=1 during and after rst; load_valid while RUN is ignored.
REQ-037 Scoreboard SHALL compare every word against a reference-model schedule for 100 random chunks per mode.

Source files
------------

// File: rtl/miner_core_pkg.sv
// miner_core_pkg
//   Shared constants and types for the message-schedule stream:
//   - word widths and round counts for the SHA-256 and SHA-512 schedules
//   - rotate/shift amounts of the small sigma0/sigma1 functions
//   - the schedule FSM state type
package miner_core_pkg;

   localparam int SHA256_WORD_W = 32;
   localparam int SHA256_ROUNDS = 64;
   localparam int SHA512_WORD_W = 64;
   localparam int SHA512_ROUNDS = 80;

   // Round index width: holds every t for both schedules (0..79).
   localparam int IDX_W     = 7;
   // Sliding window depth: W[t] only depends on the previous 16 words.
   localparam int WIN_DEPTH = 16;

   // SHA-256 small sigma: s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10
   localparam int SHA256_S0_ROT_A = 7;
   localparam int SHA256_S0_ROT_B = 18;
   localparam int SHA256_S0_SHR   = 3;
   localparam int SHA256_S1_ROT_A = 17;
   localparam int SHA256_S1_ROT_B = 19;
   localparam int SHA256_S1_SHR   = 10;

   // SHA-512 small sigma: s0 = ROTR1^ROTR8^SHR7, s1 = ROTR19^ROTR61^SHR6
   localparam int SHA512_S0_ROT_A = 1;
   localparam int SHA512_S0_ROT_B = 8;
   localparam int SHA512_S0_SHR   = 7;
   localparam int SHA512_S1_ROT_A = 19;
   localparam int SHA512_S1_ROT_B = 61;
   localparam int SHA512_S1_SHR   = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/miner_core_sigma.sv
// miner_core_sigma
//   Combinational small sigma functions of the message schedule.
//   Ports:
//     x_lo  in   WORD_W  operand of sigma0 (the older word, window slot 1)
//     x_hi  in   WORD_W  operand of sigma1 (the newer word, window slot 14)
//     s0    out  WORD_W  sigma0(x_lo)
//     s1    out  WORD_W  sigma1(x_hi)
//   SHA512 selects the 64-bit SHA-512 variant instead of the 32-bit SHA-256 one.
module miner_core_sigma
   import miner_core_pkg::*;
#(
   parameter bit SHA512 = 1'b0,
   localparam int WORD_W = SHA512 ? SHA512_WORD_W : SHA256_WORD_W
) (
   input  logic [WORD_W-1:0] x_lo,
   input  logic [WORD_W-1:0] x_hi,
   output logic [WORD_W-1:0] s0,
   output logic [WORD_W-1:0] s1
);

   localparam int S0_A = SHA512 ? SHA512_S0_ROT_A : SHA256_S0_ROT_A;
   localparam int S0_B = SHA512 ? SHA512_S0_ROT_B : SHA256_S0_ROT_B;
   localparam int S0_S = SHA512 ? SHA512_S0_SHR   : SHA256_S0_SHR;
   localparam int S1_A = SHA512 ? SHA512_S1_ROT_A : SHA256_S1_ROT_A;
   localparam int S1_B = SHA512 ? SHA512_S1_ROT_B : SHA256_S1_ROT_B;
   localparam int S1_S = SHA512 ? SHA512_S1_SHR   : SHA256_S1_SHR;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   always_comb begin
      s0 = rotr(x_lo, S0_A) ^ rotr(x_lo, S0_B) ^ (x_lo >> S0_S);
      s1 = rotr(x_hi, S1_A) ^ rotr(x_hi, S1_B) ^ (x_hi >> S1_S);
   end

endmodule

// File: rtl/miner_core_msa_stream.sv
// miner_core_msa_stream
//   Streams the message schedule W[0..ROUNDS-1] of one 16-word block.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     load_valid   in   a block is offered on chunk
//     load_ready   out  idle, the offered block will be taken
//     chunk        in   16*WORD_W message block, word 0 at the MSBs
//     abort        in   synchronous cancel, wins over load and transfer
//     w_valid      out  w_data holds W[t]
//     w_ready      in   consumer takes W[t]
//     w_data       out  schedule word W[t]
//     w_idx        out  round index t
//     w_last       out  W[t] is the final word (t == ROUNDS-1)
//     state_dbg    out  current FSM state, for observation only
//
// Handshakes: a beat moves on a rising edge where valid && ready. A source
// holding valid keeps its payload stable until that edge; valid never
// depends on ready in the same cycle.
module miner_core_msa_stream
   import miner_core_pkg::*;
#(
   parameter bit SHA512 = 1'b0,
   localparam int WORD_W = SHA512 ? SHA512_WORD_W : SHA256_WORD_W,
   localparam int ROUNDS = SHA512 ? SHA512_ROUNDS : SHA256_ROUNDS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [16*WORD_W-1:0]   chunk,
   input  logic                   abort,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [WORD_W-1:0]      w_data,
   output logic [IDX_W-1:0]       w_idx,
   output logic                   w_last,
   output state_t                 state_dbg
);

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(ROUNDS - 2);

   state_t             state;
   logic [WORD_W-1:0]  win [WIN_DEPTH];
   logic [IDX_W-1:0]   t;
   logic [WORD_W-1:0]  s0;
   logic [WORD_W-1:0]  s1;
   logic [WORD_W-1:0]  next_word;

   // win[0] is W[t]; win[1], win[9], win[14] are W[t+1], W[t+9], W[t+14],
   // i.e. W[t+16-15], W[t+16-7], W[t+16-2] for the word entering slot 15.
   miner_core_sigma #(.SHA512(SHA512)) u_sigma (
      .x_lo (win[1]),
      .x_hi (win[14]),
      .s0   (s0),
      .s1   (s1)
   );

   // Sum wraps at WORD_W bits, discarding carries as the hash requires.
   assign next_word = s1 + win[9] + s0 + win[0];

   // Both are direct register outputs.
   assign w_data    = win[0];
   assign w_idx     = t;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         load_ready <= 1'b1;
         w_valid    <= 1'b0;
         w_last     <= 1'b0;
         t          <= '0;
         for (int k = 0; k < WIN_DEPTH; k++) win[k] <= '0;
      end else if (abort) begin
         state      <= ST_IDLE;
         load_ready <= 1'b1;
         w_valid    <= 1'b0;
         w_last     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_valid) begin
                  for (int k = 0; k < WIN_DEPTH; k++)
                     win[k] <= chunk[(WIN_DEPTH-1-k)*WORD_W +: WORD_W];
                  t          <= '0;
                  w_last     <= 1'b0;
                  w_valid    <= 1'b1;
                  load_ready <= 1'b0;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               // w_valid is always high here, so w_ready alone means a transfer.
               if (w_ready) begin
                  for (int k = 0; k < WIN_DEPTH-1; k++) win[k] <= win[k+1];
                  win[WIN_DEPTH-1] <= next_word;
                  t      <= t + 7'd1;
                  w_last <= (t == PENULT_IDX);
                  if (t == LAST_IDX) begin
                     w_valid    <= 1'b0;
                     load_ready <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               load_ready <= 1'b1;
               w_valid    <= 1'b0;
               w_last     <= 1'b0;
            end
         endcase
      end
   end

endmodule
